// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer engine and its clock generator.
package spi_pkg;
    localparam int SPI_NSS_NUM   = 4;
    localparam int SPI_TRL_WIDTH = 16;

    typedef enum logic [1:0] {STD = 2'd0, DUAL = 2'd1, QUAD = 2'd2} spi_mode_e;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} spi_state_e;

    // The reserved encoding falls back to single-lane operation.
    function automatic spi_mode_e to_mode(input logic [1:0] m);
        return (m == 2'd3) ? STD : spi_mode_e'(m);
    endfunction
endpackage

// File: rtl/spi_clkgen.sv
// SCK divider: toggles SCK every div+1 cycles while run is high, else parks at cpol.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 cpol,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 sck,
    output logic                 lead_edge,
    output logic                 trail_edge
);
    logic [DIV_WIDTH-1:0] cnt;
    logic                 tick;

    // Edge pulses fire in the cycle before SCK actually toggles.
    assign tick       = run && (cnt == div);
    assign lead_edge  = tick && (sck == cpol);
    assign trail_edge = tick && (sck != cpol);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= cpol;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_xfer_engine.sv
// Multi-word SPI master: standard/dual/quad lanes, CPOL/CPHA, MSB/LSB order,
// valid/ready word streams toward the TX and RX FIFOs.
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int NSS_NUM    = SPI_NSS_NUM,
    parameter int DATA_WIDTH = 32,
    parameter int TRL_WIDTH  = SPI_TRL_WIDTH,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NSS_NUM-1:0]    nss_i,
    input  logic [NSS_NUM-1:0]    csv_i,
    input  logic                  ass_i,
    input  logic                  lsb_i,
    input  logic                  st_i,
    input  logic                  rwm_i,
    input  logic [1:0]            mode_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic [TRL_WIDTH-1:0]  trl_i,
    output logic                  busy_o,
    output logic                  last_o,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  spi_sck_o,
    output logic [NSS_NUM-1:0]    spi_nss_o,
    output logic [3:0]            spi_io_en_o,
    input  logic [3:0]            spi_io_in_i,
    output logic [3:0]            spi_io_out_o
);
    localparam int BW = $clog2(DATA_WIDTH);

    spi_state_e            state, state_nx;
    spi_mode_e             mode;
    logic                  rwm, lsb, cpol, cpha;
    logic [DIV_WIDTH-1:0]  div;
    logic [TRL_WIDTH-1:0]  trl, word;
    logic [BW-1:0]         beat, beat_last;
    logic [DATA_WIDTH-1:0] txs, rxs, tx_nx, rx_nx;
    logic [3:0]            tx_grp;
    logic                  lead, trail, multi_rd, multi_wr, more, end_word;
    logic [NSS_NUM-1:0]    sel;

    assign multi_rd = (mode != STD) && rwm;
    assign multi_wr = (mode != STD) && !rwm;
    assign more     = (word != trl);
    assign end_word = trail && (beat == beat_last);

    spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
        .clk        (clk_i),
        .rst        (rst_i),
        .run        (state == SHIFT),
        .cpol       ((state == IDLE) ? cpol_i : cpol),
        .div        (div),
        .sck        (spi_sck_o),
        .lead_edge  (lead),
        .trail_edge (trail)
    );

    // Lane-group datapath: current output group plus next shift/sample values.
    always_comb begin
        tx_grp    = 4'd0;
        tx_nx     = txs;
        rx_nx     = rxs;
        beat_last = BW'(DATA_WIDTH - 1);
        case (mode)
            QUAD: begin
                beat_last = BW'(DATA_WIDTH / 4 - 1);
                tx_grp    = lsb ? txs[3:0] : txs[DATA_WIDTH-1 -: 4];
                tx_nx     = lsb ? (txs >> 4) : (txs << 4);
                rx_nx     = lsb ? {spi_io_in_i, rxs[DATA_WIDTH-1:4]}
                                : {rxs[DATA_WIDTH-5:0], spi_io_in_i};
            end
            DUAL: begin
                beat_last = BW'(DATA_WIDTH / 2 - 1);
                tx_grp    = {2'b00, lsb ? txs[1:0] : txs[DATA_WIDTH-1 -: 2]};
                tx_nx     = lsb ? (txs >> 2) : (txs << 2);
                rx_nx     = lsb ? {spi_io_in_i[1:0], rxs[DATA_WIDTH-1:2]}
                                : {rxs[DATA_WIDTH-3:0], spi_io_in_i[1:0]};
            end
            default: begin
                tx_grp = {3'b000, lsb ? txs[0] : txs[DATA_WIDTH-1]};
                tx_nx  = lsb ? (txs >> 1) : (txs << 1);
                rx_nx  = lsb ? {spi_io_in_i[1], rxs[DATA_WIDTH-1:1]}
                             : {rxs[DATA_WIDTH-2:0], spi_io_in_i[1]};
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (st_i) state_nx = LOAD;
            LOAD:    if (multi_rd || tx_valid_i) state_nx = SHIFT;
            SHIFT:   if (end_word) state_nx = multi_wr ? (more ? LOAD : DONE) : STORE;
            STORE:   if (rx_ready_i) state_nx = more ? LOAD : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            mode  <= STD;
            rwm   <= 1'b0;
            lsb   <= 1'b0;
            cpol  <= 1'b0;
            cpha  <= 1'b0;
            div   <= '0;
            trl   <= '0;
            word  <= '0;
            beat  <= '0;
            txs   <= '0;
            rxs   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (st_i) begin
                    mode <= to_mode(mode_i);
                    rwm  <= rwm_i;
                    lsb  <= lsb_i;
                    cpol <= cpol_i;
                    cpha <= cpha_i;
                    div  <= div_i;
                    trl  <= trl_i;
                    word <= '0;
                end
                LOAD: if (multi_rd || tx_valid_i) begin
                    txs  <= multi_rd ? '0 : tx_data_i;
                    beat <= '0;
                end
                SHIFT: begin
                    // With cpha=1 the first group is already on the lanes from LOAD.
                    if (lead) begin
                        if (!cpha)           rxs <= rx_nx;
                        else if (beat != '0) txs <= tx_nx;
                    end
                    if (trail) begin
                        if (!cpha) txs <= tx_nx;
                        else       rxs <= rx_nx;
                        beat <= beat + 1'b1;
                        if (end_word && multi_wr && more) word <= word + 1'b1;
                    end
                end
                STORE: if (rx_ready_i && more) word <= word + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_o     = (state != IDLE);
    assign last_o     = (state == LOAD || state == SHIFT || state == STORE) && !more;
    assign tx_ready_o = (state == LOAD) && !multi_rd;
    assign rx_valid_o = (state == STORE);
    assign rx_data_o  = rxs;

    always_comb begin
        spi_io_en_o  = 4'b0000;
        spi_io_out_o = 4'b0000;
        if (state != IDLE) begin
            spi_io_out_o = tx_grp;
            case (mode)
                QUAD:    spi_io_en_o = rwm ? 4'b0000 : 4'b1111;
                DUAL:    spi_io_en_o = rwm ? 4'b0000 : 4'b0011;
                default: spi_io_en_o = 4'b0001;
            endcase
        end
    end

    assign sel       = nss_i & {NSS_NUM{busy_o | ~ass_i}};
    assign spi_nss_o = ~(sel ^ csv_i);
endmodule

// File: doc/spi_xfer_engine.md
Name: spi_xfer_engine

Overview:
Parametrised successor to the single-lane SPI core. Runs a complete multi-word SPI master transfer with a programmable SCK divider, CPOL/CPHA, MSB/LSB order, and standard, dual or quad lane modes. Exposes valid/ready streams toward the TX/RX FIFOs and drives SCK, NSS and the four IO lanes. Sits between the register/FIFO layer and the pad mux.

Parameters:
NSS_NUM, 4, number of slave-select outputs (1..4)
DATA_WIDTH, 32, word width in bits; must be a multiple of 4
TRL_WIDTH, 16, width of the transfer-length field
DIV_WIDTH, 8, width of the clock divider field

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
nss_i  in  NSS_NUM  slave-select enables
csv_i  in  NSS_NUM  active level per NSS (1 = active-high)
ass_i  in  1  auto slave select: NSS active only while busy_o
lsb_i  in  1  1 = LSB first
st_i  in  1  start pulse
rwm_i  in  1  dual/quad direction: 0 = write, 1 = read
mode_i  in  2  0 = standard, 1 = dual, 2 = quad, 3 = reserved (treated as standard)
cpol_i  in  1  SCK idle level
cpha_i  in  1  clock phase
div_i  in  DIV_WIDTH  SCK half-period = div_i+1 clk cycles
trl_i  in  TRL_WIDTH  word count minus 1
busy_o  out  1  transfer in progress
last_o  out  1  final word being shifted
tx_valid_i/tx_ready_o  in/out  1  TX word handshake
tx_data_i  in  DATA_WIDTH  TX word
rx_valid_o/rx_ready_i  out/in  1  RX word handshake
rx_data_o  out  DATA_WIDTH  RX word
spi_sck_o  out  1  SPI clock
spi_nss_o  out  NSS_NUM  slave selects
spi_io_en_o  out  4  lane output enables
spi_io_in_i  in  4  lane inputs
spi_io_out_o  out  4  lane outputs

Behaviour:
- Reset: busy_o, last_o, tx_ready_o, rx_valid_o = 0; rx_data_o = 0; spi_sck_o = 0; spi_io_en_o = 0; spi_io_out_o = 0; FSM = IDLE; all counters = 0.
- Configuration inputs are latched on the accepted start. Changes while busy are ignored.
- Lanes L = 1/2/4 by mode. Beats per word = DATA_WIDTH/L. Beats are shifted MSB-group first, or LSB-group first when lsb_i = 1.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE: on st_i=1, go to LOAD and set busy_o=1 on the next cycle. st_i while busy is ignored.
- LOAD: tx_ready_o=1. When tx_valid_i=1, capture the word and go to SHIFT. In dual/quad read mode, LOAD skips the TX handshake and loads zeros. If TX is empty, SCK stays at the idle level (pause, no timeout).
- SHIFT: divider counts 0..div_i. At terminal count SCK toggles, giving edges alternately as leading and trailing.
- cpha=0: first beat is driven during LOAD→SHIFT. Sample on leading edge, shift on trailing edge.
- cpha=1: shift on leading edge, sample on trailing edge.
- After the last beat's final edge, go to STORE.
- STORE: rx_valid_o=1 with the assembled word, held until rx_ready_i=1. In dual/quad write mode, STORE is skipped.
- After STORE, go to LOAD if words remain, else DONE. SCK is held at cpol while waiting (RX full stalls the bus).
- DONE: one cycle; busy_o=0 on the next cycle; return to IDLE.
- last_o=1 from LOAD of the final word through its STORE.
- Standard mode: io_en=4'b0001, io_out[0]=MOSI, MISO sampled from io_in[1].
- Dual mode: io_en=4'b0011 for write, 0 for read; uses lanes [1:0].
- Quad mode: io_en=4'b1111 for write, 0 for read; uses lanes [3:0].
- IDLE: io_en=0, spi_sck_o=cpol_i.
- NSS: sel = nss_i & (busy_o | ~ass_i); spi_nss_o = ~(sel ^ csv_i).
- div_i=0 gives an SCK period of 2 clk cycles.
- Reset mid-transfer aborts immediately to reset values. No partial RX word is emitted.

Decomposition:
- Shared package spi_pkg holds:
  - spi_mode_e (STD, DUAL, QUAD)
  - fsm state enum
  - SPI_NSS_NUM and SPI_TRL_WIDTH defaults
- One sub-module, spi_clkgen, parametrised by DIV_WIDTH. Outputs sck, lead_edge and trail_edge pulses, and is gated by a run input.

Test Plan:
- Standard, cpol=0, cpha=0, div=1, trl=0, TX 0xA5A5_0F0F, MSB first, loopback io_out[0]→io_in[1] → 32 SCK pulses of period 4 clk; rx_data_o=0xA5A5_0F0F; last_o high throughout; busy_o falls after DONE.
- Same with lsb_i=1, cpha=1, cpol=1 → SCK idles high; bit 0 appears first on MOSI; RX matches TX.
- Quad write, trl=2, three words 0x1234_5678, 0x9ABC_DEF0, 0xFFFF_0000 → 8 SCK per word; io_en=4'hF; nibbles 1,2,3,…; no rx_valid_o.
- Quad read, io_in driven with nibble sequence 0xC0FFEE00 → rx_data_o=0xC0FF_EE00; io_en=0; tx_ready_o never asserted.
- Standard, trl=1, tx_valid_i withheld 20 cycles before word 2 and rx_ready_i withheld 15 cycles → SCK stays at cpol during both stalls; no data lost.
- ass_i=1, nss_i=4'b0010, csv_i=0 → spi_nss_o=4'b1101 only while busy, 4'b1111 otherwise. rst_i asserted mid-word → all outputs return to reset values in the same cycle.
